dma_rd_engine: RTL
==================

Name: dma_rd_engine

Overview:
AXI4 burst-read DMA engine directly downstream of the AXI-Lite CSR block. It consumes start, base-address and length, fetches memory through an AXI4 read master, and streams the words out on AXI-Stream. It reports done and error levels back to the CSR status register. One transfer is handled at a time, with one burst outstanding.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI and stream data width. Fixed at 4 bytes per beat.
- MAX_BURST, 16, maximum beats per burst. A 64 B burst on a 64 B-aligned base never crosses a 4 KB boundary.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_start  in  1  single-cycle start pulse from the CSR
- i_base_addr  in  32  source byte address
- i_len  in  32  transfer length in bytes
- o_busy  out  1  transfer in progress
- o_done  out  1  level: last transfer finished
- o_error  out  1  level: last transfer failed
- m_axi_araddr  out  ADDR_WIDTH  burst address
- m_axi_arlen  out  8  beats minus 1
- m_axi_arsize  out  3  constant 3'b010
- m_axi_arburst  out  2  constant 2'b01 (INCR)
- m_axi_arvalid  out  1
- m_axi_arready  in  1
- m_axi_rdata  in  DATA_WIDTH
- m_axi_rresp  in  2
- m_axi_rlast  in  1
- m_axi_rvalid  in  1
- m_axi_rready  out  1
- m_axis_tdata  out  DATA_WIDTH
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tlast  out  1  final word of the whole transfer

Behaviour:
- Clock and reset: clk; rst_n asynchronous, active-low.
- Reset values: all outputs 0, except m_axi_arsize=3'b010 and m_axi_arburst=2'b01 (constants). FSM in IDLE.
- FSM states: IDLE, ADDR, DATA, FLUSH.
- IDLE, i_start=1: latch base and length; clear o_done and o_error.
  - If i_len==0: o_done=1 next cycle, no AXI traffic.
  - Else if i_len[1:0]!=0 or i_base_addr[5:0]!=0: o_error=1 and o_done=1 next cycle, no AXI traffic.
  - Else: rem_beats=i_len>>2 (30 bits), cur_addr=base, o_busy=1, go to ADDR.
- i_start while o_busy=1 is ignored, with no side effects.
- ADDR: arvalid=1, araddr=cur_addr, arlen=min(rem_beats,MAX_BURST)-1.
  - araddr and arlen are held stable until arready.
  - On the arvalid&arready handshake go to DATA; a burst beat counter loads the burst length.
- DATA: rready = !tvalid_reg | m_axis_tready (one-entry output register, no bubbles at full throughput).
  - Each R handshake loads rdata into the output register with tvalid=1.
  - tlast=1 when this beat is the final beat of the whole transfer.
  - rresp!=2'b00 on any beat sets the sticky error flag; all remaining beats are still accepted and forwarded.
  - rlast is checked against the beat counter. Mismatch (early rlast, or missing rlast on the counted last beat) sets the sticky error flag. The beat counter governs burst completion.
  - On the last counted beat: rem_beats -= burst, cur_addr += burst*4. If rem_beats is now 0 go to FLUSH, else go to ADDR.
- FLUSH: wait until the output register drains (tvalid&tready on the tlast word). Then o_done=1, o_error=sticky flag, o_busy=0, return to IDLE.
- Latency: start to arvalid is 1 cycle. R beat to tvalid is 1 cycle.
- o_done and o_error hold until the next accepted start.
- Stream backpressure: stalling tready stalls rready; there is no data loss and no overrun.
- Asynchronous reset mid-transfer: all state cleared immediately. The AXI slave is assumed to be reset together with this block.

Optional Feature:
- Macro DMA_PERF_CNT_EN.
- Defined: adds output o_cycles[31:0].
  - Cleared on an accepted start.
  - Increments every cycle while o_busy=1.
  - Holds its value after done, until the next start.
  - Saturates at 32'hFFFF_FFFF.
- Not defined: no port, no counter logic.

Test Plan:
- base=0x1000, len=256, arready and rvalid always 1, tready=1: 4 bursts, araddr 0x1000/0x1040/0x1080/0x10C0, arlen=15 each. 64 stream words in order, tlast on word 64 only. o_done=1, o_error=0.
- base=0x2000, len=72: bursts arlen=15 then arlen=1 at 0x2040. 18 words, tlast on word 18.
- base=0x1004, len=64: no arvalid ever, o_done=1 and o_error=1 next cycle. len=0 with base=0x1000: o_done=1, o_error=0.
- len=128, rresp=2'b10 on beat 5 of burst 0: all 32 words still streamed, then o_done=1 and o_error=1.
- len=64 with tready toggled 1-0-0-1 repeatedly: rready tracks backpressure, all 16 words delivered exactly once. Second i_start pulsed mid-transfer is ignored.
- With DMA_PERF_CNT_EN, len=64, zero-wait slave, tready=1: o_cycles equals the measured busy cycles (implementation-checked, about 19). Reset asserted mid-burst leaves all outputs 0 immediately.

Source files
------------

// File: rtl/dma_rd_engine.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// dma_rd_engine
//
// AXI4 burst-read DMA engine. A start pulse from the CSR block latches a
// source byte address and a byte length. The engine fetches the region with
// INCR bursts of at most MAX_BURST beats, keeping one burst in flight. Every
// returned word is forwarded through a one-entry AXI-Stream output register.
// Done and error are reported as levels that hold until the next accepted
// start.
//
// Optional feature (compile-time macro DMA_PERF_CNT_EN):
//   Adds o_cycles[31:0], a saturating count of busy cycles. The count is
//   cleared on every accepted start and holds its value after completion.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   i_start                 single-cycle start pulse (ignored while busy)
//   i_base_addr, i_len      source byte address and byte length
//   o_busy                  transfer in progress
//   o_done, o_error         status levels for the last transfer
//   o_cycles                busy-cycle counter (DMA_PERF_CNT_EN only)
//   m_axi_ar*               AXI4 read-address channel (master)
//   m_axi_r*                AXI4 read-data channel (master)
//   m_axis_t*               AXI-Stream output; tlast marks the final word
// ---------------------------------------------------------------------------
module dma_rd_engine #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [31:0]           i_base_addr,
    input  logic [31:0]           i_len,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
`ifdef DMA_PERF_CNT_EN
    output logic [31:0]           o_cycles,
`endif
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ADDR  = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    // Wide enough to hold any legal MAX_BURST (up to 256 beats).
    localparam int BEAT_W = 9;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [29:0]           rem_beats;    // beats not yet completed, whole transfer
    logic [BEAT_W-1:0]     burst_beats;  // size of the burst in flight
    logic [BEAT_W-1:0]     beat_cnt;     // beats still owed by the burst in flight
    logic                  err_sticky;

    logic [BEAT_W-1:0]     next_burst;
    logic                  ar_fire;
    logic                  r_fire;
    logic                  s_fire;
    logic                  last_beat;
    logic                  final_beat;
    logic                  bad_align;

    // Size of the next burst: the remaining beats, capped at MAX_BURST.
    // NOTE: every always_comb output gets a default on all paths so no latch is inferred.
    always_comb begin
        next_burst = BEAT_W'(MAX_BURST);
        if (rem_beats < 30'(MAX_BURST)) begin
            next_burst = BEAT_W'(rem_beats);
        end
    end

    assign m_axi_arvalid = (state == ST_ADDR);
    // Gated so the bus reads all-zero outside ADDR (rem_beats=0 would give arlen=8'hFF).
    assign m_axi_araddr  = m_axi_arvalid ? cur_addr : '0;
    assign m_axi_arlen   = m_axi_arvalid ? 8'(next_burst - BEAT_W'(1)) : 8'd0;
    assign m_axi_arsize  = 3'b010;
    assign m_axi_arburst = 2'b01;

    // Accept a beat whenever the output register is empty or is draining this cycle.
    assign m_axi_rready  = (state == ST_DATA) && (!m_axis_tvalid || m_axis_tready);

    assign ar_fire    = m_axi_arvalid && m_axi_arready;
    assign r_fire     = m_axi_rvalid && m_axi_rready;
    assign s_fire     = m_axis_tvalid && m_axis_tready;
    assign last_beat  = (beat_cnt == BEAT_W'(1));
    assign final_beat = last_beat && (rem_beats == 30'(burst_beats));
    assign bad_align  = (i_len[1:0] != 2'b00) || (i_base_addr[5:0] != 6'd0);

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cur_addr      <= '0;
            rem_beats     <= '0;
            burst_beats   <= '0;
            beat_cnt      <= '0;
            err_sticky    <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_error       <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            // One-entry output register: a new beat overwrites a word that drains this cycle.
            if (r_fire) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= m_axi_rdata;
                m_axis_tlast  <= final_beat;
            end else if (s_fire) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        o_done  <= 1'b0;
                        o_error <= 1'b0;
                        if (i_len == 32'd0) begin
                            o_done <= 1'b1;
                        end else if (bad_align) begin
                            o_done  <= 1'b1;
                            o_error <= 1'b1;
                        end else begin
                            cur_addr   <= ADDR_WIDTH'(i_base_addr);
                            rem_beats  <= i_len[31:2];
                            err_sticky <= 1'b0;
                            o_busy     <= 1'b1;
                            state      <= ST_ADDR;
                        end
                    end
                end

                ST_ADDR: begin
                    if (ar_fire) begin
                        burst_beats <= next_burst;
                        beat_cnt    <= next_burst;
                        state       <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (r_fire) begin
                        // rlast is only cross-checked; the beat counter decides burst end.
                        if ((m_axi_rresp != 2'b00) || (m_axi_rlast != last_beat)) begin
                            err_sticky <= 1'b1;
                        end
                        beat_cnt <= beat_cnt - BEAT_W'(1);
                        if (last_beat) begin
                            rem_beats <= rem_beats - 30'(burst_beats);
                            cur_addr  <= cur_addr + ADDR_WIDTH'({burst_beats, 2'b00});
                            state     <= final_beat ? ST_FLUSH : ST_ADDR;
                        end
                    end
                end

                ST_FLUSH: begin
                    // The register holds the tlast word on entry; finish once it is taken.
                    if (s_fire) begin
                        o_done  <= 1'b1;
                        o_error <= err_sticky;
                        o_busy  <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef DMA_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_cycles <= '0;
        end else if ((state == ST_IDLE) && i_start) begin
            o_cycles <= '0;
        end else if (o_busy && (o_cycles != 32'hFFFF_FFFF)) begin
            o_cycles <= o_cycles + 32'd1;
        end
    end
`endif

endmodule
